// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and port indices for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; last_grant advances only when a grant is taken
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_idx,
    output logic       gnt_valid
);
    logic last_grant;
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req[0] && req[1]) ? ~last_grant : req[1];
    end
    // Reset to the DMA port so the CPU wins the first tie
    always_ff @(posedge clk) begin
        if (!rst)
            last_grant <= P_DMA;
        else if (take && gnt_valid)
            last_grant <= gnt_idx;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer for two requesters sharing a single-port data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic              we_q, gnt_q, range_err, gnt_idx, gnt_valid;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       addr_sel;
    rr_arb2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       ({req1, req0}),
        .take      (state == IDLE),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );
    assign addr_sel  = gnt_idx ? addr1 : addr0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    always_comb begin
        nxt = (state == IDLE)   ? (gnt_valid ? ACCESS : IDLE) :
              (state == ACCESS) ? ((cnt == '0) ? DONE : ACCESS) : IDLE;
        busy      = state != IDLE;
        mem_write = state == ACCESS && cnt == '0 && we_q && !range_err;
        ack0      = state == DONE && gnt_q == P_CPU;
        ack1      = state == DONE && gnt_q == P_DMA;
        err       = state == DONE && range_err;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            gnt_q     <= 1'b0;
            range_err <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && gnt_valid) begin
                we_q      <= gnt_idx ? we1 : we0;
                wdata_q   <= gnt_idx ? wdata1 : wdata0;
                addr_q    <= addr_sel[ADDR_W-1:0];
                range_err <= |addr_sel[31:ADDR_W];
                gnt_q     <= gnt_idx;
                cnt       <= CW'(LAT - 1);
            end else if (state == ACCESS) begin
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                else
                    rdata <= (we_q || range_err) ? '0 : mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench; instance a runs LAT=1, instance b runs LAT=3
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  ra, rb, ack_a, ack_b;
    logic [31:0] rdata_a, rdata_b, mwd_a, mwd_b, mrd_a, mrd_b;
    logic        err_a, err_b, busy_a, busy_b, mw_a, mw_b;
    logic [6:0]  ma_a, ma_b, last_wa;
    logic [31:0] mem_a [128];
    logic [31:0] mem_b [128];
    typedef struct {logic port; logic [31:0] rdata; logic err;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int total = 0, bad = 0, wr_a = 0, wr_b = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .LAT(1)) u_a (
        .clk(clk), .rst(rst),
        .req0(ra[0]), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack_a[0]),
        .req1(ra[1]), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack_a[1]),
        .rdata(rdata_a), .err(err_a), .busy(busy_a),
        .mem_write(mw_a), .mem_addr(ma_a), .mem_wdata(mwd_a), .mem_rdata(mrd_a)
    );
    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .LAT(3)) u_b (
        .clk(clk), .rst(rst),
        .req0(rb[0]), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack_b[0]),
        .req1(rb[1]), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack_b[1]),
        .rdata(rdata_b), .err(err_b), .busy(busy_b),
        .mem_write(mw_b), .mem_addr(ma_b), .mem_wdata(mwd_b), .mem_rdata(mrd_b)
    );

    assign mrd_a = mem_a[ma_a];
    assign mrd_b = mem_b[ma_b];
    always @(posedge clk) begin
        if (mw_a) mem_a[ma_a] <= mwd_a;
        if (mw_b) mem_b[ma_b] <= mwd_b;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int i, input logic [1:0] ack, input logic [31:0] rd, input logic er);
        exp_t e;
        if (ack == 2'b00) return;
        chk("ack_onehot", {31'd0, ack == 2'b11}, 32'd0);
        if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack inst=%0d: got ack=%b want none", i, ack);
            return;
        end
        if (i == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        chk("ack_port", {31'd0, ack[1]}, {31'd0, e.port});
        chk("rdata", rd, e.rdata);
        chk("err", {31'd0, er}, {31'd0, e.err});
    endtask

    always @(negedge clk) begin
        mon(0, ack_a, rdata_a, err_a);
        mon(1, ack_b, rdata_b, err_b);
        if (mw_a) begin
            wr_a++;
            last_wa = ma_a;
            chk("mw_a_busy", {31'd0, busy_a}, 32'd1);
        end
        if (mw_b) begin
            wr_b++;
            chk("mw_b_busy", {31'd0, busy_b}, 32'd1);
        end
    end

    // Counts negedges until the wanted ack appears; a timeout shows up as a latency mismatch
    task automatic wait_ack(input int i, input int p, input int want, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(i == 1 ? ack_b[p] : ack_a[p]) && n < 20);
        chk(nm, n, want);
    endtask

    initial begin
        for (int k = 0; k < 128; k++) begin
            mem_a[k] = 32'd0;
            mem_b[k] = 32'd0;
        end
        mem_a[0] = 32'h1234_5678;
        mem_a[1] = 32'h0000_0011;
        mem_a[2] = 32'h0000_0022;
        mem_b[7] = 32'h0000_0077;
        mem_b[9] = 32'h0000_0099;
        rst = 1'b0; ra = 2'b00; rb = 2'b00;
        we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_acks", {28'd0, ack_a, ack_b}, 32'd0);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd0);
        chk("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
        chk("rst_mem_write", {31'd0, mw_a}, 32'd0);
        chk("rst_mem_addr", {25'd0, ma_a}, 32'd0);
        chk("rst_mem_wdata", mwd_a, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        // store to word 5 from the CPU port
        we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hDEAD_BEEF; ra[0] = 1'b1;
        qa.push_back('{1'b0, 32'd0, 1'b0});
        wait_ack(0, 0, 2, "t1_latency");
        ra[0] = 1'b0;
        @(negedge clk);
        chk("t1_writes", wr_a, 32'd1);
        chk("t1_write_addr", {25'd0, last_wa}, 32'd5);
        chk("t1_mem5", mem_a[5], 32'hDEAD_BEEF);
        // DMA reads it back
        we1 = 1'b0; addr1 = 32'd5; ra[1] = 1'b1;
        qa.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
        wait_ack(0, 1, 2, "t2_latency");
        ra[1] = 1'b0;
        @(negedge clk);
        chk("t2_writes", wr_a, 32'd1);
        // contention: CPU loads word 1, DMA loads word 2, alternating from the CPU
        we0 = 1'b0; addr0 = 32'd1; addr1 = 32'd2;
        for (int k = 0; k < 4; k++)
            qa.push_back('{k[0], (k[0] ? 32'h22 : 32'h11), 1'b0});
        ra = 2'b11;
        for (int k = 0; k < 4; k++)
            wait_ack(0, k % 2, (k == 0) ? 2 : 3, "t3_alt_latency");
        ra = 2'b00;
        @(negedge clk);
        chk("t3_writes", wr_a, 32'd1);
        // out-of-range store aliases word 0 but must not touch it
        we0 = 1'b1; addr0 = 32'h0000_0080; wdata0 = 32'hCAFE_F00D; ra[0] = 1'b1;
        qa.push_back('{1'b0, 32'd0, 1'b1});
        wait_ack(0, 0, 2, "t4_latency");
        ra[0] = 1'b0;
        @(negedge clk);
        chk("t4_writes", wr_a, 32'd1);
        chk("t4_mem0", mem_a[0], 32'h1234_5678);
        // LAT=3 load with req dropped after grant; first of four negedges spent here
        we1 = 1'b0; addr1 = 32'd7; rb[1] = 1'b1;
        qb.push_back('{1'b1, 32'h77, 1'b0});
        @(negedge clk);
        rb[1] = 1'b0;
        wait_ack(1, 1, 3, "t5_latency");
        @(negedge clk);
        chk("t5_writes", wr_b, 32'd0);
        // reset during the first ACCESS cycle of a LAT=3 store
        we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'hBAD0_BAD0; rb[0] = 1'b1;
        @(negedge clk);
        chk("t6_busy_before", {31'd0, busy_b}, 32'd1);
        rst = 1'b0; rb[0] = 1'b0;
        @(negedge clk);
        chk("t6_busy", {31'd0, busy_b}, 32'd0);
        chk("t6_acks", {30'd0, ack_b}, 32'd0);
        chk("t6_rdata", rdata_b, 32'd0);
        chk("t6_err", {31'd0, err_b}, 32'd0);
        chk("t6_mem_write", {31'd0, mw_b}, 32'd0);
        chk("t6_mem_addr", {25'd0, ma_b}, 32'd0);
        chk("t6_mem_wdata", mwd_b, 32'd0);
        chk("t6_mem9", mem_b[9], 32'h0000_0099);
        chk("t6_writes", wr_b, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_qa", qa.size(), 32'd0);
        chk("drain_qb", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
